// File: rtl/scr1_imem_ahb_flush_if.sv
// Bundle of the IMEM fetch port and the instruction AHB-Lite bus for
// scr1_imem_ahb_flush.
//
// Handshake: a fetch is transferred on a cycle where imem_req and
// imem_req_ack are both high. imem_req_ack never depends on imem_req.
// On AHB, an address phase is accepted on the cycle where htrans is NONSEQ
// and hready is high. The data phase completes on the first later cycle
// with hready high. imem_resp reports RDY_OK/RDY_ER for exactly one cycle
// per completed, unflushed fetch.
interface scr1_imem_ahb_flush_if #(
    parameter int AHB_WIDTH = 32
);
    logic                 imem_req;
    logic [AHB_WIDTH-1:0] imem_addr;
    logic                 imem_flush;
    logic                 imem_req_ack;
    logic [AHB_WIDTH-1:0] imem_rdata;
    logic [1:0]           imem_resp;
    logic [3:0]           hprot;
    logic [2:0]           hburst;
    logic [2:0]           hsize;
    logic                 hmastlock;
    logic [1:0]           htrans;
    logic [AHB_WIDTH-1:0] haddr;
    logic                 hready;
    logic [AHB_WIDTH-1:0] hrdata;
    logic                 hresp;

    // Bridge side: consumes core requests and bus responses.
    modport master (
        input  imem_req, imem_addr, imem_flush, hready, hrdata, hresp,
        output imem_req_ack, imem_rdata, imem_resp, hprot, hburst, hsize,
        output hmastlock, htrans, haddr
    );

    // Environment side: core plus AHB slave.
    modport slave (
        output imem_req, imem_addr, imem_flush, hready, hrdata, hresp,
        input  imem_req_ack, imem_rdata, imem_resp, hprot, hburst, hsize,
        input  hmastlock, htrans, haddr
    );
endinterface

// File: rtl/scr1_imem_ahb_flush.sv
// IMEM to AHB-Lite fetch bridge with a request FIFO, an optional registered
// response path and a flush that discards queued and in-flight fetches.
module scr1_imem_ahb_flush #(
    parameter int AHB_WIDTH = 32,
    parameter int REQ_DEPTH = 2,
    parameter int RESP_REG  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scr1_imem_ahb_flush_if.master bus,
    output logic                  dbg_fsm
);
    localparam int             CW       = $clog2(REQ_DEPTH + 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(REQ_DEPTH);
    localparam logic [0:0]     ST_ADDR  = 1'b0;
    localparam logic [0:0]     ST_DATA  = 1'b1;
    localparam logic [1:0]     HT_IDLE  = 2'b00;
    localparam logic [1:0]     HT_NSEQ  = 2'b10;

    logic [0:0]           fsm, fsm_d;
    logic [CW-1:0]        cnt, cnt_d, wr_idx;
    logic [AHB_WIDTH-1:0] fifo_q [REQ_DEPTH];
    logic [AHB_WIDTH-1:0] fifo_d [REQ_DEPTH];
    logic                 drop_r;
    logic                 fifo_empty, fifo_full;
    logic                 wr, pop, issue, resp_fire;

    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == FULL_CNT);

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign bus.imem_req_ack = ~fifo_full & ~bus.imem_flush;
    assign wr               = bus.imem_req & bus.imem_req_ack;
    assign pop              = issue & bus.hready;

    assign bus.hprot     = 4'b0000;
    assign bus.hburst    = 3'b000;
    assign bus.hsize     = 3'b010;
    assign bus.hmastlock = 1'b0;
    assign bus.htrans    = issue ? HT_NSEQ : HT_IDLE;
    assign bus.haddr     = fifo_q[0];
    assign dbg_fsm       = fsm[0];

    // Decide whether the FIFO head goes out as an address phase this cycle.
    always_comb begin
        issue = 1'b0;
        fsm_d = fsm;
        case (fsm)
            ST_ADDR: begin
                issue = ~fifo_empty & ~bus.imem_flush;
                if (issue && bus.hready) fsm_d = ST_DATA;
            end
            ST_DATA: begin
                // An ERROR completion never pipelines; queued entries go out from ADDR.
                if (bus.hready) begin
                    if (!bus.hresp) issue = ~fifo_empty & ~bus.imem_flush;
                    fsm_d = issue ? ST_DATA : ST_ADDR;
                end
            end
            default: fsm_d = ST_ADDR;
        endcase
    end

    // Next FIFO contents: shift on pop, new entry lands behind the survivors.
    always_comb begin
        fifo_d = fifo_q;
        wr_idx = cnt - CW'(pop);
        if (pop) begin
            for (int i = 0; i < REQ_DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
        end
        if (wr) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                if (wr_idx == CW'(i)) fifo_d[i] = bus.imem_addr;
            end
        end
        cnt_d = bus.imem_flush ? '0 : (cnt + CW'(wr) - CW'(pop));
    end

    // FSM, occupancy and FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm <= ST_ADDR;
            cnt <= '0;
            for (int i = 0; i < REQ_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            fsm    <= fsm_d;
            cnt    <= cnt_d;
            fifo_q <= fifo_d;
        end
    end

    // Remember that a stalled data phase was flushed so its response is swallowed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_r <= 1'b0;
        end else if (fsm == ST_DATA) begin
            if (bus.imem_flush && !bus.hready) drop_r <= 1'b1;
            else if (bus.hready)               drop_r <= 1'b0;
        end
    end

    assign resp_fire = (fsm == ST_DATA) & bus.hready & ~bus.imem_flush & ~drop_r;

    if (RESP_REG != 0) begin : g_resp_reg
        logic                 resp_valid_r;
        logic                 err_r;
        logic [AHB_WIDTH-1:0] rdata_r;

        // Capture the completing response; data holds between responses.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                resp_valid_r <= 1'b0;
                err_r        <= 1'b0;
                rdata_r      <= '0;
            end else begin
                resp_valid_r <= resp_fire;
                if (resp_fire) begin
                    err_r   <= bus.hresp;
                    rdata_r <= bus.hrdata;
                end
            end
        end

        assign bus.imem_resp  = resp_valid_r ? (err_r ? 2'b10 : 2'b01) : 2'b00;
        assign bus.imem_rdata = rdata_r;
    end else begin : g_resp_comb
        assign bus.imem_resp  = resp_fire ? (bus.hresp ? 2'b10 : 2'b01) : 2'b00;
        assign bus.imem_rdata = bus.hrdata;
    end
endmodule

// File: tb/tb_scr1_imem_ahb_flush.sv
// Bench for scr1_imem_ahb_flush: a registered-response and a combinational-
// response instance share one stimulus stream and one AHB slave, and both
// are compared every cycle against a transaction-level model.
module tb_scr1_imem_ahb_flush;
  localparam int W     = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req_t, flush_t, hready_t, hresp_t;
  logic [W-1:0] addr_t, hrdata_t;
  logic         dbg_r, dbg_c;

  scr1_imem_ahb_flush_if #(.AHB_WIDTH(W)) bus_r ();
  scr1_imem_ahb_flush_if #(.AHB_WIDTH(W)) bus_c ();

  assign bus_r.imem_req   = req_t;
  assign bus_r.imem_addr  = addr_t;
  assign bus_r.imem_flush = flush_t;
  assign bus_r.hready     = hready_t;
  assign bus_r.hresp      = hresp_t;
  assign bus_r.hrdata     = hrdata_t;
  assign bus_c.imem_req   = req_t;
  assign bus_c.imem_addr  = addr_t;
  assign bus_c.imem_flush = flush_t;
  assign bus_c.hready     = hready_t;
  assign bus_c.hresp      = hresp_t;
  assign bus_c.hrdata     = hrdata_t;

  scr1_imem_ahb_flush #(.AHB_WIDTH(W), .REQ_DEPTH(DEPTH), .RESP_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(bus_r), .dbg_fsm(dbg_r));
  scr1_imem_ahb_flush #(.AHB_WIDTH(W), .REQ_DEPTH(DEPTH), .RESP_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .bus(bus_c), .dbg_fsm(dbg_c));

  // ---------------- model state ----------------
  logic [W-1:0] exp_q[$];       // accepted, not yet issued addresses
  logic         m_infl, m_drop, m_rv, m_rerr;
  logic [W-1:0] m_infl_addr, m_rdata;
  logic         e_ack, e_issue, e_done, e_fire;
  logic [1:0]   obs_htrans;
  logic [W-1:0] obs_haddr;

  // ---------------- slave state ----------------
  logic         s_act, s_err;
  int           s_wait;
  logic [W-1:0] s_addr;
  bit           dir_mode;
  int           cfg_wait_q[$];
  bit           cfg_err_q[$];

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] t2_exp [4] = '{32'hA5C3_0000, 32'hA5C3_0004, 32'hA5C3_0008, 32'hA5C3_000C};
  logic [W-1:0] t2_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

  function automatic logic [W-1:0] data_of(input logic [W-1:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5C3_0000);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_infl = 0; m_drop = 0; m_rv = 0; m_rerr = 0;
    m_infl_addr = '0; m_rdata = '0;
    s_act = 0; s_err = 0; s_wait = 0; s_addr = '0;
  endtask

  // ---------------- driver ----------------
  task automatic cyc_begin(input logic req, input logic [W-1:0] addr,
                           input logic flush, input logic rst);
    @(negedge clk);
    rst_n = rst; req_t = req; addr_t = addr; flush_t = flush;
    if (s_act) begin
      hready_t = (s_wait == 0);
      hresp_t  = s_err && (s_wait <= 1);
      hrdata_t = data_of(s_addr);
    end else begin
      hready_t = 1'b1;
      hresp_t  = 1'b0;
      hrdata_t = $urandom;
    end
    #1;
    e_ack   = (exp_q.size() < DEPTH) && !flush;
    e_issue = !flush && (exp_q.size() > 0) && (!m_infl || (hready_t && !hresp_t));
    e_done  = m_infl && hready_t;
    e_fire  = e_done && !flush && !m_drop;

    chk("ack_r", bus_r.imem_req_ack, e_ack);
    chk("ack_c", bus_c.imem_req_ack, e_ack);
    chk("htrans_r", bus_r.htrans, e_issue ? 2'b10 : 2'b00);
    chk("htrans_c", bus_c.htrans, e_issue ? 2'b10 : 2'b00);
    if (e_issue) begin
      chk("haddr_r", bus_r.haddr, exp_q[0]);
      chk("haddr_c", bus_c.haddr, exp_q[0]);
    end
    chk("dbg_r", dbg_r, m_infl);
    chk("dbg_c", dbg_c, m_infl);
    chk("resp_c", bus_c.imem_resp, e_fire ? (hresp_t ? 2'b10 : 2'b01) : 2'b00);
    if (e_fire) chk("rdata_c", bus_c.imem_rdata, data_of(m_infl_addr));
    chk("resp_r", bus_r.imem_resp, m_rv ? (m_rerr ? 2'b10 : 2'b01) : 2'b00);
    chk("rdata_r", bus_r.imem_rdata, m_rdata);
    chk("const_r", {bus_r.hprot, bus_r.hburst, bus_r.hsize, bus_r.hmastlock}, 11'b0000_000_010_0);
    chk("const_c", {bus_c.hprot, bus_c.hburst, bus_c.hsize, bus_c.hmastlock}, 11'b0000_000_010_0);
    obs_htrans = bus_r.htrans;
    obs_haddr  = bus_r.haddr;
  endtask

  task automatic cyc_end();
    logic [W-1:0] fin;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      fin = m_infl_addr;
      if (e_fire) begin m_rv = 1; m_rerr = hresp_t; m_rdata = data_of(fin); end
      else m_rv = 0;
      if (flush_t && m_infl && !hready_t) m_drop = 1;
      else if (e_done) m_drop = 0;
      if (e_done) m_infl = 0;
      if (e_issue && hready_t) begin m_infl = 1; m_infl_addr = exp_q.pop_front(); end
      if (flush_t) exp_q.delete();
      else if (req_t && e_ack) exp_q.push_back(addr_t);
      // slave
      if (s_act) begin
        if (hready_t) s_act = 0;
        else s_wait--;
      end
      if (obs_htrans == 2'b10 && hready_t) begin
        s_act = 1; s_addr = obs_haddr;
        if (dir_mode) begin
          s_wait = (cfg_wait_q.size() > 0) ? cfg_wait_q.pop_front() : 0;
          s_err  = (cfg_err_q.size() > 0) ? cfg_err_q.pop_front() : 1'b0;
        end else begin
          s_wait = $urandom_range(0, 2);
          s_err  = ($urandom_range(0, 7) == 0);
          if (s_err && s_wait == 0) s_wait = 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic req, input logic [W-1:0] addr, input logic flush, input logic rst);
    cyc_begin(req, addr, flush, rst);
    cyc_end();
  endtask

  task automatic cfg(input int w, input bit e);
    cfg_wait_q.push_back(w);
    cfg_err_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] got[$];
    bit saw_nack;
    int k;
    rst_n = 0; req_t = 0; addr_t = '0; flush_t = 0;
    hready_t = 1; hresp_t = 0; hrdata_t = '0;
    model_reset();
    dir_mode = 1;
    repeat (2) @(posedge clk);

    // single fetch, zero-wait; also pins the post-reset outputs
    cyc_begin(1, 32'h100, 0, 1);
    chk("rst_ack", bus_r.imem_req_ack, 1);
    chk("rst_htrans", bus_r.htrans, 0);
    chk("rst_haddr", bus_r.haddr, 0);
    chk("rst_resp", bus_r.imem_resp, 0);
    chk("rst_rdata", bus_r.imem_rdata, 0);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t1_htrans", bus_r.htrans, 2'b10);
    chk("t1_haddr", bus_r.haddr, 32'h100);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t1_resp_c", bus_c.imem_resp, 2'b01);
    chk("t1_rdata_c", bus_c.imem_rdata, 32'hDEAD_BEEF);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t1_resp_r", bus_r.imem_resp, 2'b01);
    chk("t1_rdata_r", bus_r.imem_rdata, 32'hDEAD_BEEF);
    cyc_end();

    // back-to-back fill with two wait states per transfer
    repeat (4) cfg(2, 0);
    k = 0; saw_nack = 0;
    for (int c = 0; c < 30; c++) begin
      cyc_begin(k < 4, (k < 4) ? t2_addr[k] : '0, 0, 1);
      if (k < 4 && !bus_r.imem_req_ack) saw_nack = 1;
      if (bus_c.imem_resp == 2'b01) got.push_back(bus_c.imem_rdata);
      if (k < 4 && e_ack) k++;
      cyc_end();
    end
    chk("t2_nack_seen", saw_nack, 1);
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4; i++) if (i < got.size()) chk("t2_order", got[i], t2_exp[i]);

    // two-cycle ERROR on 0x200 with 0x204 queued
    cfg(1, 1);
    cyc(1, 32'h200, 0, 1);
    cyc_begin(1, 32'h204, 0, 1);
    chk("t3_issue_htrans", bus_r.htrans, 2'b10);
    chk("t3_issue_haddr", bus_r.haddr, 32'h200);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t3_err1_htrans", bus_r.htrans, 2'b00);
    chk("t3_err1_resp_c", bus_c.imem_resp, 2'b00);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t3_err2_htrans", bus_r.htrans, 2'b00);
    chk("t3_err2_resp_c", bus_c.imem_resp, 2'b10);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t3_reissue_htrans", bus_r.htrans, 2'b10);
    chk("t3_reissue_haddr", bus_r.haddr, 32'h204);
    chk("t3_err_resp_r", bus_r.imem_resp, 2'b10);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t3_ok_resp_c", bus_c.imem_resp, 2'b01);
    chk("t3_ok_rdata_c", bus_c.imem_rdata, 32'hA5C3_0204);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t3_ok_resp_r", bus_r.imem_resp, 2'b01);
    cyc_end();

    // flush during a wait-stated data phase with two entries queued
    cfg(2, 0);
    cyc(1, 32'h300, 0, 1);
    cyc(1, 32'h304, 0, 1);
    cyc(1, 32'h308, 0, 1);
    cyc_begin(0, 0, 1, 1);
    chk("t4_flush_ack", bus_r.imem_req_ack, 0);
    chk("t4_flush_htrans", bus_r.htrans, 2'b00);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t4_drop_resp_c", bus_c.imem_resp, 2'b00);
    chk("t4_drop_htrans", bus_r.htrans, 2'b00);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t4_drop_resp_r", bus_r.imem_resp, 2'b00);
    chk("t4_empty_htrans", bus_r.htrans, 2'b00);
    cyc_end();
    cyc(1, 32'h400, 0, 1);
    cyc_begin(0, 0, 0, 1);
    chk("t4_new_haddr", bus_r.haddr, 32'h400);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t4_new_resp_c", bus_c.imem_resp, 2'b01);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t4_new_resp_r", bus_r.imem_resp, 2'b01);
    chk("t4_new_rdata_r", bus_r.imem_rdata, 32'hA5C3_0400);
    cyc_end();

    // flush with a concurrent request
    cyc_begin(1, 32'h500, 1, 1);
    chk("t5_ack", bus_r.imem_req_ack, 0);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t5_htrans", bus_r.htrans, 2'b00);
    cyc_end();
    repeat (2) cyc(0, 0, 0, 1);

    // reset in the middle of a wait-stated data phase
    cfg(2, 0);
    cyc(1, 32'h600, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc_begin(0, 0, 0, 1);
    chk("t6_htrans", bus_r.htrans, 2'b00);
    chk("t6_resp_c", bus_c.imem_resp, 2'b00);
    chk("t6_resp_r", bus_r.imem_resp, 2'b00);
    chk("t6_ack", bus_c.imem_req_ack, 1);
    cyc_end();
    cyc(1, 32'h0, 0, 1);
    cyc_begin(0, 0, 0, 1);
    chk("t6_fetch_htrans", bus_c.htrans, 2'b10);
    chk("t6_fetch_haddr", bus_c.haddr, 32'h0);
    cyc_end();
    cyc_begin(0, 0, 0, 1);
    chk("t6_fetch_resp_c", bus_c.imem_resp, 2'b01);
    chk("t6_fetch_rdata_c", bus_c.imem_rdata, 32'hA5C3_0000);
    cyc_end();
    cyc(0, 0, 0, 1);

    // randomized traffic against the model
    dir_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 9) < 6), ($urandom & 32'hFFFF_FFFC),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) != 0));
    end
    cyc(0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
